uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Consumes the byte stream from the UART receiver (rx data + 1-cycle strobe) and assembles
//  ASCII command lines "<letter>[hex digits]<CR|LF>" into a single command word.
//  Sits downstream of uart_rx, alongside the echo FIFO; feeds the register/control logic in clk_48.
//  Malformed lines are discarded and flagged; completed commands are held until consumed.
// PARAMETERS
//  ARG_WIDTH   32  width of cmd_arg; must be a multiple of 4; MAX_DIGITS = ARG_WIDTH/4
// PORTS
//  clk_48       in   1          system clock, 48 MHz
//  reset        in   1          synchronous, active-high
//  rx_data      in   8          received byte, valid only when rx_strobe=1
//  rx_strobe    in   1          1-cycle pulse per received byte
//  cmd_valid    out  1          command held for consumer
//  cmd_ready    in   1          consumer accepts command when cmd_valid && cmd_ready
//  cmd_op       out  8          command letter, folded to upper case ('A'..'Z')
//  cmd_arg      out  ARG_WIDTH  hex argument, right-aligned, zero if no digits
//  cmd_has_arg  out  1          1 if at least one hex digit was received
//  err_strobe   out  1          1-cycle pulse when a line is rejected
//  overrun      out  1          1-cycle pulse when a byte is dropped in HOLD
//  echo_data    out  8          echoed byte (optional feature)
//  echo_strobe  out  1          1-cycle echo pulse (optional feature)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; arg accumulator 0; digit count 0. Reset mid-line discards it.
//  Bytes are processed only on rx_strobe cycles; a strobe is never ignored without a defined action.
//  States: IDLE, ARG, ERR, HOLD.
//  IDLE: ' ', TAB, CR, LF ignored (a CR LF pair yields one command, LF is swallowed here).
//    'A'-'Z'/'a'-'z' -> latch upper-case op, clear arg and count, -> ARG.
//    any other byte -> err_strobe, -> ERR.
//  ARG: hex digit (0-9, a-f, A-F) with count<MAX_DIGITS -> arg <= {arg[ARG_WIDTH-5:0], nibble},
//    count++. Digit with count==MAX_DIGITS -> err_strobe, -> ERR (no wrap, no truncation).
//    ' ' / TAB ignored. CR or LF -> -> HOLD. Any other byte -> err_strobe, -> ERR.
//  ERR: discard all bytes until CR or LF, then -> IDLE. No further err_strobe for the same line.
//  HOLD: cmd_valid=1; cmd_op/cmd_arg/cmd_has_arg stable for the whole state.
//    cmd_ready=1 -> -> IDLE; cmd_valid low the following cycle.
//    rx_strobe in HOLD (including the cycle cmd_ready is sampled) -> byte dropped, overrun pulse.
//  Latency: cmd_valid rises on the cycle after the terminator's rx_strobe.
//    err_strobe/overrun rise on the cycle after the offending rx_strobe; each lasts exactly 1 cycle.
//  cmd_ready while not in HOLD has no effect. Back-to-back lines: the next line's letter is
//    accepted on the first strobe after leaving HOLD.
//  Outputs registered; no combinational path from rx_* or cmd_ready to any output.
// CONFIGURATION
//  UART_CMD_PARSER_ECHO_EN defined: every byte not dropped by HOLD is copied to echo_data with
//    echo_strobe 1 cycle after its rx_strobe (same cycle as any err/valid effect); lower-case
//    letters are echoed unmodified. Downstream is a FIFO into uart_tx; no backpressure.
//  Undefined: echo_strobe and echo_data are constant 0; no echo logic synthesised.
// TESTING
//  "R\r" -> cmd_valid 1 cycle after '\r', cmd_op=0x52, cmd_arg=0, cmd_has_arg=0; held until cmd_ready.
//  "w 1f\n" -> cmd_op=0x57, cmd_arg=0x0000001F, cmd_has_arg=1; then "\n" alone -> no command.
//  "A123456789\r" (9 digits, ARG_WIDTH=32) -> err_strobe on 9th digit, no cmd_valid; "B5\r" -> op 'B', arg 5.
//  "#x\rZ\r" -> one err_strobe on '#', ERR until '\r', then command 'Z' with no arg.
//  In HOLD with cmd_ready=0, send "Q" -> overrun pulse, command unchanged; cmd_ready=1 -> IDLE next cycle.
//  Reset asserted after "C12" -> no command; then "D\r" -> op 'D', arg 0. With _EN: each byte echoed at +1 cycle.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Command hand-off bundle between uart_cmd_parser and its consumer.
// The parser is master; the register/control logic is slave.
interface uart_cmd_parser_if #(
    parameter int ARG_WIDTH = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_op;
    logic [ARG_WIDTH-1:0] cmd_arg;
    logic                 cmd_has_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output cmd_has_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  cmd_has_arg,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles "<letter>[hex]<CR|LF>" lines from uart_rx into command words.
// Optional byte echo is enabled by defining UART_CMD_PARSER_ECHO_EN.
module uart_cmd_parser #(
    parameter int ARG_WIDTH = 32
) (
    input  logic       clk_48,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    uart_cmd_parser_if.master cmd,
    output logic       err_strobe,
    output logic       overrun,
    output logic [7:0] echo_data,
    output logic       echo_strobe
);
    localparam int MAX_DIGITS = ARG_WIDTH / 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARG,
        S_ERR,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           op_q, op_d;
    logic [ARG_WIDTH-1:0] arg_q, arg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 ovr_q, ovr_d;

    logic       is_ws;
    logic       is_eol;
    logic       is_letter;
    logic       is_hex;
    logic [3:0] nib;

    // Classify the incoming byte and derive its hex nibble value
    always_comb begin
        is_ws     = (rx_data == 8'h20) || (rx_data == 8'h09);
        is_eol    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_letter = ((rx_data >= 8'h41) && (rx_data <= 8'h5A)) ||
                    ((rx_data >= 8'h61) && (rx_data <= 8'h7A));
        is_hex    = 1'b0;
        nib       = 4'h0;
        if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0];
        end else if (((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                     ((rx_data >= 8'h61) && (rx_data <= 8'h66))) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end
    end

    // Line-assembly FSM: next state, accumulator and pulse requests
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        if (rx_strobe) begin
            unique case (state_q)
                S_IDLE: begin
                    unique case (1'b1)
                        is_ws, is_eol: ;
                        is_letter: begin
                            op_d    = {rx_data[7:6], 1'b0, rx_data[4:0]};
                            arg_d   = '0;
                            cnt_d   = '0;
                            state_d = S_ARG;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    endcase
                end
                S_ARG: begin
                    unique case (1'b1)
                        is_hex: begin
                            if (cnt_q == CW'(MAX_DIGITS)) begin
                                err_d   = 1'b1;
                                state_d = S_ERR;
                            end else begin
                                arg_d = {arg_q[ARG_WIDTH-5:0], nib};
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        is_ws: ;
                        is_eol: state_d = S_HOLD;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    endcase
                end
                S_ERR: begin
                    if (is_eol) begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: ovr_d = 1'b1;
            endcase
        end
        if ((state_q == S_HOLD) && cmd.cmd_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and command registers
    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd.cmd_valid   = (state_q == S_HOLD);
    assign cmd.cmd_op      = op_q;
    assign cmd.cmd_arg     = arg_q;
    assign cmd.cmd_has_arg = (cnt_q != '0);
    assign err_strobe      = err_q;
    assign overrun         = ovr_q;

`ifdef UART_CMD_PARSER_ECHO_EN
    logic [7:0] echo_data_q;
    logic       echo_strobe_q;
    logic       echo_take;

    assign echo_take = rx_strobe && (state_q != S_HOLD);

    // Copy every byte not dropped by HOLD towards the tx echo FIFO
    always_ff @(posedge clk_48) begin
        if (reset) begin
            echo_data_q   <= '0;
            echo_strobe_q <= 1'b0;
        end else begin
            echo_strobe_q <= echo_take;
            if (echo_take) begin
                echo_data_q <= rx_data;
            end
        end
    end

    assign echo_data   = echo_data_q;
    assign echo_strobe = echo_strobe_q;
`else
    assign echo_data   = 8'h00;
    assign echo_strobe = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed cases then random lines.
// A line-level reference model predicts commands, errors and overruns.
module tb_uart_cmd_parser;
    localparam int AW   = 32;
    localparam int MAXD = AW / 4;

    logic       clk_48 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       err_strobe;
    logic       overrun;
    logic [7:0] echo_data;
    logic       echo_strobe;

    uart_cmd_parser_if #(.ARG_WIDTH(AW)) cmd_if ();

    uart_cmd_parser #(.ARG_WIDTH(AW)) dut (
        .clk_48      (clk_48),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .cmd         (cmd_if),
        .err_strobe  (err_strobe),
        .overrun     (overrun),
        .echo_data   (echo_data),
        .echo_strobe (echo_strobe)
    );

    always #10 clk_48 = ~clk_48;

    typedef struct {
        logic [7:0]    op;
        logic [AW-1:0] arg;
        logic          has;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] line_q[$];
    logic [7:0] echo_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int exp_err = 0;
    int got_err = 0;
    int exp_ovr = 0;
    int got_ovr = 0;
    int n_hs = 0;
    bit auto_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return -1;
    endfunction

    function automatic bit is_alpha(input logic [7:0] b);
        return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
    endfunction

    function automatic bit is_blank(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09);
    endfunction

    // Judge a whole completed line: blank, a command, or a single error
    task automatic eval_line(output bit made);
        int         i;
        int         nd;
        bit         ok;
        logic [7:0] c;
        exp_t       e;
        made = 1'b0;
        i = 0;
        while (i < line_q.size() && is_blank(line_q[i])) i++;
        if (i == line_q.size()) return;
        c = line_q[i];
        if (!is_alpha(c)) begin
            exp_err++;
            return;
        end
        e.op  = (c >= "a") ? c - 8'd32 : c;
        e.arg = '0;
        ok = 1'b1;
        nd = 0;
        for (int j = i + 1; j < line_q.size(); j++) begin
            if (is_blank(line_q[j])) continue;
            if (hexval(line_q[j]) < 0) begin
                ok = 1'b0;
            end else begin
                nd++;
                if (nd <= MAXD) e.arg = e.arg * 16 + AW'(hexval(line_q[j]));
            end
        end
        if (ok && nd <= MAXD) begin
            e.has = (nd > 0);
            exp_q.push_back(e);
            made = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit made);
        made = 1'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            eval_line(made);
            line_q.delete();
        end else begin
            line_q.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit drop, output bit made);
        made = 1'b0;
        if (drop) exp_ovr++;
        else begin
            model_byte(b, made);
            echo_q.push_back(b);
        end
        @(posedge clk_48);
        #1;
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk_48);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic send_str(input string s);
        bit m;
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, m);
    endtask

    task automatic wait_accept();
        int t0;
        int k;
        t0 = n_hs;
        k = 0;
        while (n_hs == t0 && k < 200) begin
            @(posedge clk_48);
            k++;
        end
        check("accept_timeout", 64'(n_hs != t0), 64'd1);
    endtask

    task automatic accept_manual();
        cmd_if.cmd_ready = 1'b1;
        @(posedge clk_48);
        #1;
        cmd_if.cmd_ready = 1'b0;
        check("valid_drop", 64'(cmd_if.cmd_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_48);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk_48);
        #1;
        reset = 1'b0;
        line_q.delete();
    endtask

    function automatic logic [7:0] pick_hex();
        int v;
        v = $urandom_range(0, 15);
        if (v < 10) return 8'(48 + v);
        return ($urandom_range(0, 1) != 0) ? 8'(87 + v) : 8'(55 + v);
    endfunction

    always @(posedge clk_48) begin
        #1;
        if (auto_ready) cmd_if.cmd_ready = ($urandom_range(0, 2) != 0);
    end

    logic          prev_valid = 1'b0;
    logic          prev_err = 1'b0;
    logic [7:0]    prev_op;
    logic [AW-1:0] prev_arg;
    logic          prev_has;

    // Monitor: counts pulses, checks hold stability, pops the scoreboard
    always @(negedge clk_48) begin
        if (!reset) begin
            if (err_strobe) begin
                got_err++;
                check("err_width", 64'(prev_err), 64'd0);
            end
            if (overrun) got_ovr++;
            if (cmd_if.cmd_valid && prev_valid) begin
                check("hold_op", 64'(cmd_if.cmd_op), 64'(prev_op));
                check("hold_arg", 64'(cmd_if.cmd_arg), 64'(prev_arg));
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 64'(cmd_if.cmd_op), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd_op", 64'(cmd_if.cmd_op), 64'(e.op));
                    check("cmd_arg", 64'(cmd_if.cmd_arg), 64'(e.arg));
                    check("cmd_has_arg", 64'(cmd_if.cmd_has_arg), 64'(e.has));
                end
            end
`ifdef UART_CMD_PARSER_ECHO_EN
            if (echo_strobe) begin
                if (echo_q.size() == 0) begin
                    check("unexpected_echo", 64'(echo_data), 64'h100);
                end else begin
                    check("echo_data", 64'(echo_data), 64'(echo_q.pop_front()));
                end
            end
`else
            echo_q.delete();
            if (echo_strobe || echo_data != 8'h00)
                check("echo_off", {echo_strobe, echo_data}, 64'd0);
`endif
            prev_err   <= err_strobe;
            prev_valid <= cmd_if.cmd_valid;
            prev_op    <= cmd_if.cmd_op;
            prev_arg   <= cmd_if.cmd_arg;
            prev_has   <= cmd_if.cmd_has_arg;
        end else begin
            prev_err   <= 1'b0;
            prev_valid <= 1'b0;
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        cmd_if.cmd_ready = 1'b0;
        repeat (3) @(posedge clk_48);
        #1;
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
        check("rst_op", 64'(cmd_if.cmd_op), 64'd0);
        check("rst_arg", 64'(cmd_if.cmd_arg), 64'd0);
        check("rst_has", 64'(cmd_if.cmd_has_arg), 64'd0);
        check("rst_err", 64'(err_strobe), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);

        send_str("R\r");
        check("R_valid_lat", 64'(cmd_if.cmd_valid), 64'd1);
        check("R_op", 64'(cmd_if.cmd_op), 64'h52);
        check("R_has", 64'(cmd_if.cmd_has_arg), 64'd0);
        repeat (3) @(posedge clk_48);
        #1;
        check("R_held", 64'(cmd_if.cmd_valid), 64'd1);
        accept_manual();

        send_str("w 1f\n");
        check("w_arg", 64'(cmd_if.cmd_arg), 64'h1f);
        send(8'h51, 1'b1, m);
        check("ovr_pulse", 64'(overrun), 64'd1);
        check("ovr_op_kept", 64'(cmd_if.cmd_op), 64'h57);
        accept_manual();
        send_str("\n");
        repeat (2) @(posedge clk_48);
        #1;
        check("lf_no_cmd", 64'(cmd_if.cmd_valid), 64'd0);

        send_str("A12345678");
        send_str("9");
        check("ovf_err", 64'(err_strobe), 64'd1);
        send_str("\r");
        check("ovf_no_cmd", 64'(cmd_if.cmd_valid), 64'd0);
        send_str("B5\r");
        check("B_arg", 64'(cmd_if.cmd_arg), 64'd5);
        accept_manual();

        send_str("#");
        check("hash_err", 64'(err_strobe), 64'd1);
        send_str("x\rZ\r");
        check("Z_op", 64'(cmd_if.cmd_op), 64'h5a);
        accept_manual();

        send_str("C12");
        do_reset();
        send_str("D\r");
        check("D_op", 64'(cmd_if.cmd_op), 64'h44);
        check("D_arg", 64'(cmd_if.cmd_arg), 64'd0);
        accept_manual();

        auto_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] b[$];
            int kind;
            int nd;
            int t;
            kind = $urandom_range(0, 9);
            if (kind != 0) begin
                repeat ($urandom_range(0, 2)) b.push_back(8'h20);
                if (kind == 7) begin
                    b.push_back(($urandom_range(0, 1) != 0) ? 8'h23 : pick_hex());
                end else begin
                    t = $urandom_range(0, 25);
                    b.push_back(8'(($urandom_range(0, 1) != 0 ? 65 : 97) + t));
                end
                nd = (kind == 6) ? $urandom_range(9, 10) : $urandom_range(0, MAXD);
                for (int d = 0; d < nd; d++) begin
                    if ($urandom_range(0, 3) == 0)
                        b.push_back(($urandom_range(0, 1) != 0) ? 8'h20 : 8'h09);
                    b.push_back(pick_hex());
                end
                if (kind == 8)
                    b.insert($urandom_range(1, b.size()),
                             ($urandom_range(0, 1) != 0) ? 8'h67 : 8'h2e);
            end
            t = $urandom_range(0, 2);
            if (t != 1) b.push_back(8'h0D);
            if (t != 0) b.push_back(8'h0A);
            foreach (b[i]) begin
                send(b[i], 1'b0, m);
                if (m) wait_accept();
                repeat ($urandom_range(0, 2)) @(posedge clk_48);
            end
        end

        auto_ready = 1'b0;
        repeat (10) @(posedge clk_48);
        #1;
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("err_count", 64'(got_err), 64'(exp_err));
        check("ovr_count", 64'(got_ovr), 64'(exp_ovr));
`ifdef UART_CMD_PARSER_ECHO_EN
        check("echo_q_empty", 64'(echo_q.size()), 64'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
